// File: rtl/ball_sprite.sv
// Self-moving pong ball sprite: per-frame motion, wall bounce, paddle deflection,
// miss detection and serve/hold sequencing, plus a registered pixel-hit path.
module ball_sprite #(
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned HEIGHT      = 10,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned INIT_X      = 320,
  parameter int unsigned INIT_Y      = 240,
  parameter int unsigned SPEED_X     = 4,
  parameter int unsigned SPEED_Y     = 2,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter logic [1:0]  R           = 2'b11,
  parameter logic [1:0]  G           = 2'b11,
  parameter logic [1:0]  B           = 2'b11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               launch,
  input  logic               serve_dir,
  input  logic               hit_l,
  input  logic               hit_r,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               en,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic               miss_l,
  output logic               miss_r,
  output logic               moving
);

  localparam int unsigned SW    = COORD_W + 1;
  localparam int unsigned HW    = WIDTH / 2;
  localparam int unsigned HH    = HEIGHT / 2;
  localparam int unsigned XMIN  = HW;
  localparam int unsigned XMAX  = SCREEN_W - 1 - HW;
  localparam int unsigned YMIN  = HH;
  localparam int unsigned YMAX  = SCREEN_H - 1 - HH;
  localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [SW-1:0] XMIN_S = SW'(XMIN);
  localparam logic signed [SW-1:0] XMAX_S = SW'(XMAX);
  localparam logic signed [SW-1:0] YMIN_S = SW'(YMIN);
  localparam logic signed [SW-1:0] YMAX_S = SW'(YMAX);
  localparam logic signed [SW-1:0] STEP_X = SW'(SPEED_X);
  localparam logic signed [SW-1:0] STEP_Y = SW'(SPEED_Y);

  typedef enum logic [1:0] {IDLE, MOVING, SCORED} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_RIGHT, REQ_LEFT} req_t;

  state_t             state;
  req_t               req;
  logic               dx_right;
  logic               dy_up;
  logic [CNT_W-1:0]   hold_cnt;

  req_t               req_eff_c;
  logic               dx_eff_c;
  logic signed [SW-1:0] nx_c;
  logic signed [SW-1:0] ny_c;
  logic               en_next_c;

  // Latched paddle request merged with this cycle's hits (a lone new hit overrides).
  always_comb begin
    req_eff_c = req;
    if (hit_l && !hit_r)
      req_eff_c = REQ_RIGHT;
    else if (hit_r && !hit_l)
      req_eff_c = REQ_LEFT;

    dx_eff_c = dx_right;
    if (req_eff_c == REQ_RIGHT)
      dx_eff_c = 1'b1;
    else if (req_eff_c == REQ_LEFT)
      dx_eff_c = 1'b0;

    nx_c = dx_eff_c ? $signed({1'b0, sx}) + STEP_X : $signed({1'b0, sx}) - STEP_X;
    ny_c = dy_up    ? $signed({1'b0, sy}) - STEP_Y : $signed({1'b0, sy}) + STEP_Y;
  end

  // Strict-inequality box test; sx/sy stay inside the limits so no wrap occurs.
  always_comb begin
    en_next_c = (x > sx - COORD_W'(HW)) && (x < sx + COORD_W'(HW)) &&
                (y > sy - COORD_W'(HH)) && (y < sy + COORD_W'(HH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req      <= REQ_NONE;
      sx       <= COORD_W'(INIT_X);
      sy       <= COORD_W'(INIT_Y);
      dx_right <= 1'b1;
      dy_up    <= 1'b0;
      hold_cnt <= '0;
      en       <= 1'b0;
      r        <= 2'b00;
      g        <= 2'b00;
      b        <= 2'b00;
      miss_l   <= 1'b0;
      miss_r   <= 1'b0;
      moving   <= 1'b0;
    end else begin
      en       <= en_next_c;
      {r, g, b} <= en_next_c ? {R, G, B} : 6'b000000;
      miss_l   <= 1'b0;
      miss_r   <= 1'b0;
      req      <= frame_tick ? REQ_NONE : req_eff_c;

      case (state)
        IDLE: begin
          sx <= COORD_W'(INIT_X);
          sy <= COORD_W'(INIT_Y);
          if (launch) begin
            state    <= MOVING;
            moving   <= 1'b1;
            dx_right <= serve_dir;
            dy_up    <= 1'b0;
          end
        end

        MOVING: begin
          if (frame_tick) begin
            dx_right <= dx_eff_c;
            if (ny_c <= YMIN_S) begin
              sy    <= COORD_W'(YMIN);
              dy_up <= 1'b0;
            end else if (ny_c >= YMAX_S) begin
              sy    <= COORD_W'(YMAX);
              dy_up <= 1'b1;
            end else begin
              sy <= ny_c[COORD_W-1:0];
            end
            // Reaching either side wall is a miss; the ball freezes there.
            if (nx_c <= XMIN_S) begin
              sx       <= COORD_W'(XMIN);
              miss_l   <= 1'b1;
              state    <= SCORED;
              moving   <= 1'b0;
              hold_cnt <= '0;
            end else if (nx_c >= XMAX_S) begin
              sx       <= COORD_W'(XMAX);
              miss_r   <= 1'b1;
              state    <= SCORED;
              moving   <= 1'b0;
              hold_cnt <= '0;
            end else begin
              sx <= nx_c[COORD_W-1:0];
            end
          end
        end

        SCORED: begin
          if (frame_tick) begin
            if (hold_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
              hold_cnt <= '0;
              sx       <= COORD_W'(INIT_X);
              sy       <= COORD_W'(INIT_Y);
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_sprite.sv
// Bench for ball_sprite: pixel-box table, directed serve/bounce/miss/reset
// sequences and a random phase, all checked against an integer reference model.
module tb_ball_sprite;

  logic        clk = 1'b0;
  logic        rst, frame_tick, launch, serve_dir, hit_l, hit_r;
  logic [10:0] x, y, sx, sy;
  logic        en, miss_l, miss_r, moving;
  logic [1:0]  r, g, b;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: plain integers, direction as +1/-1.
  int m_x, m_y, m_dx, m_dy, m_st, m_hold, m_req;
  int e_en, e_ml, e_mr;

  ball_sprite dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y),
    .launch(launch), .serve_dir(serve_dir), .hit_l(hit_l), .hit_r(hit_r),
    .sx(sx), .sy(sy), .en(en), .r(r), .g(g), .b(b),
    .miss_l(miss_l), .miss_r(miss_r), .moving(moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int exp_en;
  } pix_vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the model, using the inputs present at the edge.
  task automatic model();
    int nx, ny, eff;
    e_ml = 0;
    e_mr = 0;
    e_en = (int'(x) > m_x - 5 && int'(x) < m_x + 5 &&
            int'(y) > m_y - 5 && int'(y) < m_y + 5) ? 1 : 0;
    if (hit_l && !hit_r) m_req = 1;
    else if (hit_r && !hit_l) m_req = -1;
    eff = m_req;
    if (rst) begin
      m_x = 320; m_y = 240; m_dx = 1; m_dy = 1;
      m_st = 0; m_hold = 0; m_req = 0; e_en = 0;
      return;
    end
    if (m_st == 0) begin
      if (launch) begin
        m_st = 1;
        m_dx = serve_dir ? 1 : -1;
        m_dy = 1;
      end
    end else if (m_st == 1) begin
      if (frame_tick) begin
        if (eff != 0) m_dx = eff;
        ny = m_y + 2 * m_dy;
        if (ny <= 5) begin m_y = 5; m_dy = 1; end
        else if (ny >= 474) begin m_y = 474; m_dy = -1; end
        else m_y = ny;
        nx = m_x + 4 * m_dx;
        if (nx <= 5) begin m_x = 5; e_ml = 1; m_st = 2; m_hold = 0; end
        else if (nx >= 634) begin m_x = 634; e_mr = 1; m_st = 2; m_hold = 0; end
        else m_x = nx;
      end
    end else begin
      if (frame_tick) begin
        m_hold++;
        if (m_hold == 60) begin m_x = 320; m_y = 240; m_st = 0; end
      end
    end
    if (frame_tick) m_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("sx", int'(sx), m_x);
    chk("sy", int'(sy), m_y);
    chk("en", int'(en), e_en);
    chk("rgb", int'({r, g, b}), e_en ? 63 : 0);
    chk("miss_l", int'(miss_l), e_ml);
    chk("miss_r", int'(miss_r), e_mr);
    chk("moving", int'(moving), (m_st == 1) ? 1 : 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    pix_vec_t pv[8];
    int       guard;
    pv[0] = '{320, 240, 1};
    pv[1] = '{325, 240, 0};
    pv[2] = '{316, 240, 1};
    pv[3] = '{315, 240, 0};
    pv[4] = '{320, 245, 0};
    pv[5] = '{320, 236, 1};
    pv[6] = '{324, 244, 1};
    pv[7] = '{320, 235, 0};

    rst = 1'b1; frame_tick = 1'b0; launch = 1'b0; serve_dir = 1'b0;
    hit_l = 1'b0; hit_r = 1'b0; x = '0; y = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_sx", int'(sx), 320);
    chk("rst_sy", int'(sy), 240);
    chk("rst_moving", int'(moving), 0);
    chk("rst_en", int'(en), 0);

    // Pixel box table, ball at the serve position.
    for (int i = 0; i < 8; i++) begin
      x = 11'(pv[i].px);
      y = 11'(pv[i].py);
      step();
      chk("pix_en", int'(en), pv[i].exp_en);
      chk("pix_rgb", int'({r, g, b}), pv[i].exp_en ? 63 : 0);
    end
    x = '0; y = '0;

    // Serve with a coinciding tick: no step on the launch cycle.
    launch = 1'b1; serve_dir = 1'b1; frame_tick = 1'b1;
    step();
    launch = 1'b0; frame_tick = 1'b0;
    chk("launch_sx", int'(sx), 320);
    chk("launch_moving", int'(moving), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("serve_sx", int'(sx), 332);
    chk("serve_sy", int'(sy), 246);

    guard = 0;
    while (m_x != 400 && guard < 200) begin tick(); guard++; end
    chk("reach400", int'(sx), 400);
    hit_r = 1'b1; step(); hit_r = 1'b0; step(); step();
    tick();
    chk("hit_r_flip", int'(sx), 396);
    hit_r = 1'b1; step(); hit_r = 1'b0;
    tick();
    chk("hit_r_idem", int'(sx), 392);

    // Run left into the wall; y bounces off the bottom on the way.
    guard = 0;
    while (m_st == 1 && guard < 200) begin tick(); guard++; end
    chk("missl_sx", int'(sx), 5);
    chk("missl_pulse", int'(miss_l), 1);
    step();
    chk("missl_width", int'(miss_l), 0);
    launch = 1'b1;
    for (int i = 0; i < 5; i++) step();
    launch = 1'b0;
    chk("scored_launch_ign", int'(moving), 0);
    for (int i = 0; i < 59; i++) tick();
    chk("hold59_sx", int'(sx), 5);
    tick();
    chk("hold60_sx", int'(sx), 320);
    chk("hold60_sy", int'(sy), 240);

    // Serve right into the right wall.
    launch = 1'b1; serve_dir = 1'b1; step(); launch = 1'b0;
    guard = 0;
    while (m_st == 1 && guard < 200) begin tick(); guard++; end
    chk("missr_sx", int'(sx), 634);
    chk("missr_pulse", int'(miss_r), 1);
    step();
    chk("missr_width", int'(miss_r), 0);

    // Reset while in SCORED.
    for (int i = 0; i < 10; i++) tick();
    x = 11'(320); y = 11'(240);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_scored_sx", int'(sx), 320);
    chk("rst_scored_en", int'(en), 0);
    x = '0; y = '0;

    // Reset while MOVING at sx=500.
    launch = 1'b1; serve_dir = 1'b1; step(); launch = 1'b0;
    guard = 0;
    while (m_x != 500 && guard < 200) begin tick(); guard++; end
    chk("reach500", int'(sx), 500);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_moving_sx", int'(sx), 320);
    chk("rst_moving_sy", int'(sy), 240);
    chk("rst_moving_mv", int'(moving), 0);

    // Random phase against the model.
    for (int i = 0; i < 6000; i++) begin
      frame_tick = ($urandom % 8) == 0;
      launch     = ($urandom % 24) == 0;
      serve_dir  = 1'($urandom);
      hit_l      = ($urandom % 12) == 0;
      hit_r      = ($urandom % 12) == 0;
      rst        = ($urandom % 2500) == 0;
      x = 11'(m_x - 7 + int'($urandom % 15));
      y = 11'(m_y - 7 + int'($urandom % 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
